pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 3-stage (F / X / W) RV32I core. It consumes decoded X-stage control (jump, branch, load/store, reg-write, register indices) and the branch-compare result. From these it produces PC/pipeline stall, X-stage kill, PC redirect and W→X forwarding selects. It tracks the W-stage instruction internally, holds the pipeline while data memory is not ready, and keeps 32-bit stall/flush event counters for CSR readout.

Parameters:
BOOT_CYCLES, 2, cycles after reset during which fetch is held and X is killed (1..15)
FLUSH_CYCLES, 1, wrong-path instructions killed in X after a redirect (1..3; 2 for registered-output IMEM)
CNT_W, 32, width of event counters

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous reset, active low
x_reg_write  in  1  X instruction writes rd
x_is_load  in  1  X instruction is a load
x_is_store  in  1  X instruction is a store
x_jump  in  1  X instruction is JAL/JALR
x_branch  in  1  X instruction is a conditional branch
x_br_taken  in  1  branch comparator result for X
x_rd  in  5  X destination register
x_rs1  in  5  X source 1
x_rs2  in  5  X source 2
x_rs1_used  in  1  X reads rs1
x_rs2_used  in  1  X reads rs2
dmem_ready  in  1  data memory has completed the W-stage access
pc_stall  out  1  hold PC
fx_stall  out  1  hold F/X pipeline register
w_hold  out  1  hold X/W pipeline register and W-stage state
x_kill  out  1  instruction in X is invalid; datapath suppresses reg write, mem write and redirect
pc_redirect  out  1  select jump/branch target as next PC
fwd_a_sel  out  2  ALU operand A source: 00 regfile, 01 W ALU result, 10 W load data
fwd_b_sel  out  2  operand B source, same encoding
stall_count  out  CNT_W  cycles spent in MEM_WAIT
flush_count  out  CNT_W  redirects taken

Behaviour:
- All state updates on posedge clk. rst_n=0 at a posedge forces: state=BOOT, boot/flush counters=0, w_valid=w_reg_write=w_is_load=w_mem=0, w_rd=0, stall_count=flush_count=0. This applies from any state, including mid-MEM_WAIT.
- Output values while in reset/BOOT: pc_stall=1, fx_stall=0, w_hold=0, x_kill=1, pc_redirect=0, fwd selects=00.
- States: BOOT, RUN, FLUSH, MEM_WAIT. All outputs are combinational from state plus inputs.
- BOOT: counter increments each cycle; at BOOT_CYCLES-1 go to RUN. W tracking loads killed (invalid) entries.
- stall = w_valid & w_mem & ~dmem_ready. The condition is evaluated in RUN and FLUSH, and in MEM_WAIT while waiting.
  - While stall: pc_stall=fx_stall=w_hold=1 and pc_redirect=0. stall_count increments once per stalled cycle and wraps at 2^CNT_W.
  - The next state is MEM_WAIT, with the return state (RUN or FLUSH) remembered. The flush counter is frozen.
- MEM_WAIT: exit the cycle dmem_ready=1, returning to the saved state; no stall in that exit cycle.
- Redirect:
  - Condition: state RUN, ~stall, and (x_jump | (x_branch & x_br_taken)).
  - Effect: pc_redirect=1 that cycle, flush_count+1, next state FLUSH with counter=0.
- FLUSH: x_kill=1, pc_redirect=0. The counter increments on non-stalled cycles; at FLUSH_CYCLES-1 go to RUN. A jump in a killed X is ignored.
- W tracking: on every cycle with ~w_hold, capture:
  - w_valid = ~x_kill
  - w_reg_write = x_reg_write & ~x_kill
  - w_is_load = x_is_load & ~x_kill
  - w_mem = (x_is_load|x_is_store) & ~x_kill
  - w_rd = x_rd
- Forwarding for operand A (B is identical, using x_rs2 and x_rs2_used):
  - 00 if ~x_rs1_used, or x_rs1==0, or ~w_valid, or ~w_reg_write, or w_rd!=x_rs1.
  - Otherwise 10 if w_is_load, else 01.
  - Forwarding is valid during stalls; selects keep tracking the held W entry.
- No load-use stall: load data is forwarded from the W-stage memory output.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release, BOOT_CYCLES=2 → pc_stall=1, x_kill=1 for exactly 2 cycles after release, then both 0; counters read 0.
- Forwarding: X=ADD x5 (reg_write); next X=SUB x6,x5,x5 → fwd_a_sel=fwd_b_sel=01. Repeat with X rd=x0 → both 00.
- Load forward + wait: LW x7 then ADD x8,x7,x1, dmem_ready low 3 cycles → pc_stall/fx_stall/w_hold=1 for 3 cycles, fwd_a_sel=10 throughout, stall_count=3.
- Taken branch, FLUSH_CYCLES=2: x_branch=1, x_br_taken=1 → pc_redirect=1 for 1 cycle; x_kill=1 next 2 cycles with x_jump=1 injected (no second redirect); flush_count=1. Not-taken → no redirect.
- Stall during flush: redirect, then dmem_ready=0 for 2 cycles in FLUSH → x_kill stays 1 for 2+FLUSH_CYCLES cycles total; return to RUN afterwards.
- Reset mid-MEM_WAIT: assert rst_n=0 while stalled → next cycle state BOOT, w_hold=0, stall_count=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/kill/redirect/forwarding sequencer for the 3-stage F/X/W RV32I core
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_reg_write,
  input  logic             x_is_load,
  input  logic             x_is_store,
  input  logic             x_jump,
  input  logic             x_branch,
  input  logic             x_br_taken,
  input  logic [4:0]       x_rd,
  input  logic [4:0]       x_rs1,
  input  logic [4:0]       x_rs2,
  input  logic             x_rs1_used,
  input  logic             x_rs2_used,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             fx_stall,
  output logic             w_hold,
  output logic             x_kill,
  output logic             pc_redirect,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, MEM_WAIT} state_t;
  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  state_t     state, ret_state, eff;
  logic [3:0] cnt;
  logic       w_valid, w_reg_write, w_is_load, w_mem;
  logic [4:0] w_rd;
  logic       stall, redirect;
  // MEM_WAIT behaves as the interrupted state, so its exit cycle counts as a RUN or FLUSH cycle
  always_comb begin
    eff         = (state == MEM_WAIT) ? ret_state : state;
    stall       = (state != BOOT) & w_valid & w_mem & ~dmem_ready;
    redirect    = (eff == RUN) & ~stall & (x_jump | (x_branch & x_br_taken));
    pc_stall    = (state == BOOT) | stall;
    fx_stall    = stall;
    w_hold      = stall;
    x_kill      = (state == BOOT) | (eff == FLUSH);
    pc_redirect = redirect;
    fwd_a_sel   = (!x_rs1_used || x_rs1 == 5'd0 || !w_valid || !w_reg_write || w_rd != x_rs1) ? 2'b00 :
                  (w_is_load ? 2'b10 : 2'b01);
    fwd_b_sel   = (!x_rs2_used || x_rs2 == 5'd0 || !w_valid || !w_reg_write || w_rd != x_rs2) ? 2'b00 :
                  (w_is_load ? 2'b10 : 2'b01);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      ret_state   <= RUN;
      cnt         <= '0;
      w_valid     <= 1'b0;
      w_reg_write <= 1'b0;
      w_is_load   <= 1'b0;
      w_mem       <= 1'b0;
      w_rd        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!stall) begin
        w_valid     <= ~x_kill;
        w_reg_write <= x_reg_write & ~x_kill;
        w_is_load   <= x_is_load & ~x_kill;
        w_mem       <= (x_is_load | x_is_store) & ~x_kill;
        w_rd        <= x_rd;
      end
      if (stall) stall_count <= stall_count + CNT_W'(1);
      if (redirect) flush_count <= flush_count + CNT_W'(1);
      if (state == BOOT) begin
        state <= (cnt == BOOT_LAST) ? RUN : BOOT;
        cnt   <= (cnt == BOOT_LAST) ? 4'd0 : cnt + 4'd1;
      end else if (stall) begin
        state     <= MEM_WAIT;
        ret_state <= eff;
      end else if (redirect) begin
        state <= FLUSH;
        cnt   <= 4'd0;
      end else if (eff == FLUSH) begin
        state <= (cnt == FLUSH_LAST) ? RUN : FLUSH;
        cnt   <= (cnt == FLUSH_LAST) ? 4'd0 : cnt + 4'd1;
      end else begin
        state <= eff;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed sequence with an expected-output queue, BOOT_CYCLES=2, FLUSH_CYCLES=2
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_reg_write, x_is_load, x_is_store, x_jump, x_branch, x_br_taken;
  logic [4:0]  x_rd, x_rs1, x_rs2;
  logic        x_rs1_used, x_rs2_used, dmem_ready;
  logic        pc_stall, fx_stall, w_hold, x_kill, pc_redirect;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_count, flush_count;
  int          tests = 0;
  int          fails = 0;
  logic [8:0]  q[$];
  // expected vector layout: {pc_stall, fx_stall, w_hold, x_kill, pc_redirect, fwd_a, fwd_b}
  localparam logic [8:0] NONE  = 9'b00000_0000;
  localparam logic [8:0] BOOTO = 9'b10010_0000;
  localparam logic [8:0] REDIR = 9'b00001_0000;
  localparam logic [8:0] KILL  = 9'b00010_0000;
  localparam logic [8:0] STL   = 9'b11100_0000;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.BOOT_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_reg_write(x_reg_write), .x_is_load(x_is_load), .x_is_store(x_is_store),
    .x_jump(x_jump), .x_branch(x_branch), .x_br_taken(x_br_taken),
    .x_rd(x_rd), .x_rs1(x_rs1), .x_rs2(x_rs2),
    .x_rs1_used(x_rs1_used), .x_rs2_used(x_rs2_used), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .fx_stall(fx_stall), .w_hold(w_hold), .x_kill(x_kill),
    .pc_redirect(pc_redirect), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );
  task automatic setx(input logic rw, ld, st, jp, br, tk, input logic [4:0] rd, r1, r2, input logic u1, u2);
    {x_reg_write, x_is_load, x_is_store, x_jump, x_branch, x_br_taken} = {rw, ld, st, jp, br, tk};
    {x_rd, x_rs1, x_rs2, x_rs1_used, x_rs2_used} = {rd, r1, r2, u1, u2};
  endtask
  task automatic nop();
    setx(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask
  task automatic step(input string tag, input logic [8:0] e);
    logic [8:0] got, want;
    q.push_back(e);
    @(negedge clk);
    got  = {pc_stall, fx_stall, w_hold, x_kill, pc_redirect, fwd_a_sel, fwd_b_sel};
    want = q.pop_front();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    dmem_ready = 1'b1;
    nop();
    @(posedge clk);
    #1;
    step("rst0", BOOTO);
    step("rst1", BOOTO);
    step("rst2", BOOTO);
    rst_n = 1'b1;
    step("boot0", BOOTO);
    step("boot1", BOOTO);
    step("run0", NONE);
    chk("stall_cnt_init", stall_count, 0);
    chk("flush_cnt_init", flush_count, 0);
    setx(1, 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd2, 1, 1);
    step("add_x5", NONE);
    setx(1, 0, 0, 0, 0, 0, 5'd6, 5'd5, 5'd5, 1, 1);
    step("fwd_alu", 9'b00000_0101);
    setx(1, 0, 0, 0, 0, 0, 5'd9, 5'd0, 5'd0, 1, 1);
    step("rs_x0", NONE);
    setx(0, 0, 0, 0, 0, 0, 5'd0, 5'd9, 5'd9, 0, 1);
    step("rs1_unused", 9'b00000_0001);
    setx(1, 1, 0, 0, 0, 0, 5'd7, 5'd1, 5'd0, 1, 0);
    step("lw_x7", NONE);
    setx(1, 0, 0, 0, 0, 0, 5'd8, 5'd7, 5'd1, 1, 1);
    dmem_ready = 1'b0;
    step("ldwait0", STL | 9'b00000_1000);
    step("ldwait1", STL | 9'b00000_1000);
    step("ldwait2", STL | 9'b00000_1000);
    dmem_ready = 1'b1;
    step("ldexit", 9'b00000_1000);
    chk("stall_cnt_3", stall_count, 3);
    nop();
    step("after_ld", NONE);
    setx(0, 0, 0, 0, 1, 1, 5'd0, 5'd1, 5'd2, 1, 1);
    step("br_taken", REDIR);
    setx(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step("flush0_jmp", KILL);
    step("flush1_jmp", KILL);
    nop();
    step("flush_done", NONE);
    chk("flush_cnt_1", flush_count, 1);
    setx(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step("br_not_taken", NONE);
    nop();
    step("nt_next", NONE);
    chk("flush_cnt_still_1", flush_count, 1);
    setx(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step("jmp_store", REDIR);
    nop();
    dmem_ready = 1'b0;
    step("fl_stall0", STL | KILL);
    step("fl_stall1", STL | KILL);
    dmem_ready = 1'b1;
    step("fl_exit", KILL);
    step("fl_last", KILL);
    step("fl_run", NONE);
    chk("stall_cnt_5", stall_count, 5);
    chk("flush_cnt_2", flush_count, 2);
    setx(1, 1, 0, 0, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0);
    step("lw_again", NONE);
    nop();
    dmem_ready = 1'b0;
    step("mw_stall", STL);
    rst_n = 1'b0;
    step("mw_rst", STL);
    rst_n = 1'b1;
    chk("stall_cnt_rst", stall_count, 0);
    chk("flush_cnt_rst", flush_count, 0);
    step("rboot0", BOOTO);
    step("rboot1", BOOTO);
    step("rrun", NONE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
